intpol2_seq_ctrl: RTL

- Frame-level control path for the quadratic IQ interpolator datapath (I and Q lanes share control).
- Sequences input-FIFO reads into the 3-sample window (m0, m1, m2), triggers coefficient computation, and steps the fractional position x over ilen output points per segment.
- Issues output-FIFO writes under Empty/Afull flow control and reports done/busy in status_reg.
- Also supports a bypass mode that forwards samples 1:1.

---
 rtl/intpol2_seq_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/intpol2_seq_ctrl.sv
// Frame-level sequencer for the quadratic IQ interpolator: window fill, coefficient
// trigger, x stepping and output-FIFO writes, plus a 1:1 bypass path.
module intpol2_seq_ctrl #(
  parameter int FRAME_WIDTH  = 16,
  parameter int ILEN_WIDTH   = 8,
  parameter int STATUS_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FRAME_WIDTH-1:0]  cfg_frame_len,
  input  logic [ILEN_WIDTH-1:0]   cfg_ilen,
  input  logic                    cfg_bypass,
  input  logic                    Empty_i,
  input  logic                    Afull_i,
  output logic                    Read_Enable_fifo,
  output logic                    win_shift,
  output logic                    coef_en,
  output logic                    x_clr,
  output logic                    x_step,
  output logic                    Write_Enable_fifo,
  output logic [STATUS_WIDTH-1:0] status_reg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME  = 3'd1,
    S_COEF   = 3'd2,
    S_INTERP = 3'd3,
    S_FETCH  = 3'd4,
    S_SHIFT  = 3'd5,
    S_BYPASS = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] frame_q, rd_cnt_q, wr_cnt_q, seg_cnt_q;
  logic [ILEN_WIDTH-1:0]  ilen_q, out_cnt_q;
  logic [1:0]             sh_cnt_q;
  logic                   win_shift_q, bp_we_q, coef_q, done_q, busy_q, err_q;
  logic                   re_s, we_s, xstep_s, cfg_err_s, seg_last_s;

  assign cfg_err_s  = cfg_bypass ? (cfg_frame_len == {FRAME_WIDTH{1'b0}})
                                 : ((cfg_frame_len < FRAME_WIDTH'(3)) || (cfg_ilen == {ILEN_WIDTH{1'b0}}));
  assign seg_last_s = (out_cnt_q == (ilen_q - ILEN_WIDTH'(1)));

  // FIFO strobes are gated by the live flags so a pop/push never lands on an empty/full FIFO
  always_comb begin
    state_d = state_q;
    re_s    = 1'b0;
    we_s    = 1'b0;
    xstep_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = cfg_err_s ? S_DONE : (cfg_bypass ? S_BYPASS : S_PRIME);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        re_s = !Empty_i && (rd_cnt_q < FRAME_WIDTH'(3));
        if (win_shift_q && (sh_cnt_q == 2'd2)) begin
          state_d = S_COEF;
        end else begin
          state_d = S_PRIME;
        end
      end
      S_COEF: state_d = S_INTERP;
      S_INTERP: begin
        we_s    = !Afull_i;
        xstep_s = we_s && !seg_last_s;
        if (we_s && seg_last_s) begin
          state_d = ((seg_cnt_q + FRAME_WIDTH'(1)) == (frame_q - FRAME_WIDTH'(2))) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_INTERP;
        end
      end
      S_FETCH: begin
        re_s    = !Empty_i;
        state_d = re_s ? S_SHIFT : S_FETCH;
      end
      S_SHIFT: state_d = S_COEF;
      S_BYPASS: begin
        re_s = !Empty_i && !Afull_i && (rd_cnt_q < frame_q);
        if (bp_we_q && (wr_cnt_q == (frame_q - FRAME_WIDTH'(1)))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BYPASS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, latched configuration and registered control/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_q     <= {FRAME_WIDTH{1'b0}};
      ilen_q      <= {ILEN_WIDTH{1'b0}};
      rd_cnt_q    <= {FRAME_WIDTH{1'b0}};
      wr_cnt_q    <= {FRAME_WIDTH{1'b0}};
      seg_cnt_q   <= {FRAME_WIDTH{1'b0}};
      out_cnt_q   <= {ILEN_WIDTH{1'b0}};
      sh_cnt_q    <= 2'd0;
      win_shift_q <= 1'b0;
      bp_we_q     <= 1'b0;
      coef_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_shift_q <= re_s && ((state_q == S_PRIME) || (state_q == S_FETCH));
      bp_we_q     <= re_s && (state_q == S_BYPASS);
      coef_q      <= (state_d == S_COEF);
      done_q      <= (state_q == S_DONE);
      busy_q      <= (state_q != S_IDLE) && (state_q != S_DONE);
      if (state_q == S_IDLE) begin
        if (start) begin
          frame_q   <= cfg_frame_len;
          ilen_q    <= cfg_ilen;
          err_q     <= cfg_err_s;
          rd_cnt_q  <= {FRAME_WIDTH{1'b0}};
          wr_cnt_q  <= {FRAME_WIDTH{1'b0}};
          seg_cnt_q <= {FRAME_WIDTH{1'b0}};
          out_cnt_q <= {ILEN_WIDTH{1'b0}};
          sh_cnt_q  <= 2'd0;
        end else begin
          err_q <= err_q;
        end
      end else begin
        if (re_s) rd_cnt_q <= rd_cnt_q + FRAME_WIDTH'(1);
        if (bp_we_q) wr_cnt_q <= wr_cnt_q + FRAME_WIDTH'(1);
        if (win_shift_q && (state_q == S_PRIME)) sh_cnt_q <= sh_cnt_q + 2'd1;
        if (we_s) begin
          if (seg_last_s) begin
            out_cnt_q <= {ILEN_WIDTH{1'b0}};
            seg_cnt_q <= seg_cnt_q + FRAME_WIDTH'(1);
          end else begin
            out_cnt_q <= out_cnt_q + ILEN_WIDTH'(1);
          end
        end
      end
    end
  end

  assign Read_Enable_fifo  = re_s;
  assign Write_Enable_fifo = we_s || bp_we_q;
  assign x_step            = xstep_s;
  assign win_shift         = win_shift_q;
  assign coef_en           = coef_q;
  assign x_clr             = coef_q;
  assign status_reg        = {{(STATUS_WIDTH-3){1'b0}}, err_q, busy_q, done_q};

endmodule
